uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
// - 8N1 UART receiver; pairs with uart_tx over one serial line, runtime baud divisor.
// - Synchronises the async rx pin, centre-samples each bit and checks the stop bit.
// - Presents the byte in a one-entry holding register with a valid/ack handshake.
// - Sits between the pad and the bus-side peripheral wrapper; flags framing errors and overruns.
//
// PARAMETERS
// - SYNC_STAGES  default 2  flops in the rx input synchroniser (legal 2..4)
//
// PORTS
// - i_clk            in   1   system clock
// - i_rst            in   1   asynchronous, active-high reset
// - i_uart_rx        in   1   serial line, idle high, async to i_clk
// - CLKTOBAUDRATE    in   12  i_clk cycles per bit; legal 4..4095; static while o_rx_busy
// - o_rx_byte        out  8   received byte, valid while o_rx_valid
// - o_rx_valid       out  1   holding register full
// - i_rx_ack         in   1   consumer pops holding register (ignored when o_rx_valid=0)
// - o_frame_err      out  1   one-cycle pulse: stop bit sampled low
// - o_overrun        out  1   sticky: byte completed while holding register full
// - o_rx_busy        out  1   state != IDLE
//
// BEHAVIOUR
// - Reset: state=IDLE, counter=0, bit_index=0; synchroniser flops=1.
// - Reset: o_rx_byte=0, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_rx_busy=0.
// - Reset mid-frame aborts the frame immediately; no partial byte is delivered.
// - rx_s = last synchroniser stage. HALF = CLKTOBAUDRATE>>1; counter is 12-bit, cleared on every state entry.
// - IDLE: rx_s==0 -> START, counter=0.
// - START: counter increments; at counter==HALF-1 sample.
//   - Sample 1 -> false start, back to IDLE, no flag.
//   - Sample 0 -> DATA, counter=0, bit_index=0.
// - DATA: at counter==CLKTOBAUDRATE-1, sample into shreg[bit_index] (LSB first), counter=0.
//   - bit_index==7 -> STOP; else bit_index+1.
// - STOP: at counter==CLKTOBAUDRATE-1, sample the stop bit.
//   - 1 -> deliver byte (below), IDLE.
//   - 0 -> o_frame_err=1 for exactly one cycle, byte discarded, -> BREAK.
// - BREAK: wait for rx_s==1, then IDLE. A held-low line gives one frame_err only.
// - Deliver (cycle after stop sample): o_rx_byte=shreg, o_rx_valid=1.
//   - If o_rx_valid was already 1 and i_rx_ack=0 that cycle: byte overwritten, o_overrun=1.
//   - Same-cycle ack and deliver: new byte loaded, o_rx_valid stays 1, no overrun.
// - i_rx_ack with o_rx_valid=1 (no deliver that cycle): o_rx_valid=0 next cycle, o_overrun cleared.
// - Back-to-back frames: IDLE accepts a new start the cycle after STOP; minimum stop length is HALF+1 cycles.
// - CLKTOBAUDRATE<4 or changed while busy: undefined; no lockup beyond the current frame.
//
// CONFIGURATION
// - Macro UART_RX_MAJORITY_EN.
//   - Defined: every sample (start, data, stop) = majority of the last 3 rx_s values (2-flop history after rx_s).
//   - Defined: rejects single-cycle glitches at the sample point; adds 2 flops; timing otherwise unchanged.
//   - Undefined: every sample = rx_s directly.
//
// TESTING
// - CLKTOBAUDRATE=868, send 0xA5 -> one delivery, o_rx_byte=0xA5, o_rx_valid held until i_rx_ack, o_frame_err never set.
// - 100-cycle low glitch on idle line (CLKTOBAUDRATE=868) -> IDLE within 435 cycles, no o_rx_valid, no o_frame_err.
// - Frame 0x3C with stop bit 0, then line held low 20 bit-times -> one o_frame_err pulse, o_rx_valid stays 0, o_rx_busy until line high.
// - Frames 0x11 then 0x22, no ack -> o_rx_byte=0x22, o_overrun=1; i_rx_ack -> o_rx_valid=0, o_overrun=0.
// - i_rst during data bit 3 of 0xFF -> all outputs 0 next cycle; following frame 0x5A delivered correctly.
// - CLKTOBAUDRATE=16, 1-cycle inverted glitch on every data-bit sample point of 0x96.
//   - With UART_RX_MAJORITY_EN: byte=0x96.
//   - Without it: byte=0x69.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer handshake bundle for uart_rx: holding register,
// valid/ack pop, and the status flags that travel with it.
interface uart_rx_if;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       i_rx_ack;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_rx_busy;

    // Receiver side drives data and status, consumes the ack.
    modport master (
        output o_rx_byte,
        output o_rx_valid,
        output o_frame_err,
        output o_overrun,
        output o_rx_busy,
        input  i_rx_ack
    );

    // Consumer side reads data and status, drives the ack.
    modport slave (
        input  o_rx_byte,
        input  o_rx_valid,
        input  o_frame_err,
        input  o_overrun,
        input  o_rx_busy,
        output i_rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a runtime baud divisor (CLKTOBAUDRATE clocks per bit).
// Synchronises the async line, centre-samples every bit, checks the stop bit
// and hands the byte over through a one-entry holding register.
// Optional: define UART_RX_MAJORITY_EN to take every sample as the majority
// of the last three synchronised line values (single-cycle glitch rejection).
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rx,
    input  logic [11:0] CLKTOBAUDRATE,
    uart_rx_if.master   rx_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [11:0]            cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   deliver_q, deliver_d;
    logic                   ferr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   sample;
    logic [11:0]            half_m1;
    logic [11:0]            bit_m1;

    // Input synchroniser; resets to the idle (high) line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two-deep history of the synchronised line for the 2-of-3 vote.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) hist_q <= '1;
        else       hist_q <= {hist_q[0], rx_s};
    end

    assign sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_s;
`endif

    assign half_m1 = (CLKTOBAUDRATE >> 1) - 12'd1;
    assign bit_m1  = CLKTOBAUDRATE - 12'd1;

    // Next-state logic: bit timing, sampling and frame outcome.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d = '0;
                    if (sample) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == bit_m1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = sample;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == bit_m1) begin
                    cnt_d = '0;
                    if (sample) begin
                        state_d   = S_IDLE;
                        deliver_d = 1'b1;
                    end else begin
                        state_d = S_BREAK;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_BREAK: begin
                // Held-low line stays here so it reports only one framing error.
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, bit counters, shift register and the error pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            idx_q              <= '0;
            shreg_q            <= '0;
            deliver_q          <= 1'b0;
            rx_bus.o_frame_err <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            idx_q              <= idx_d;
            shreg_q            <= shreg_d;
            deliver_q          <= deliver_d;
            rx_bus.o_frame_err <= ferr_d;
        end
    end

    // Holding register: load on delivery, pop on ack, flag overwrites.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_bus.o_rx_byte  <= '0;
            rx_bus.o_rx_valid <= 1'b0;
            rx_bus.o_overrun  <= 1'b0;
        end else if (deliver_q) begin
            rx_bus.o_rx_byte  <= shreg_q;
            rx_bus.o_rx_valid <= 1'b1;
            if (rx_bus.o_rx_valid && !rx_bus.i_rx_ack)
                rx_bus.o_overrun <= 1'b1;
            else if (rx_bus.o_rx_valid && rx_bus.i_rx_ack)
                rx_bus.o_overrun <= 1'b0;
        end else if (rx_bus.o_rx_valid && rx_bus.i_rx_ack) begin
            rx_bus.o_rx_valid <= 1'b0;
            rx_bus.o_overrun  <= 1'b0;
        end
    end

    assign rx_bus.o_rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven on the falling edge,
// expected bytes queued at send time and popped when the receiver delivers.
module tb_uart_rx;

    logic        i_clk;
    logic        i_rst;
    logic        i_uart_rx;
    logic [11:0] baud;

    uart_rx_if bus ();

    uart_rx #(.SYNC_STAGES(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_uart_rx     (i_uart_rx),
        .CLKTOBAUDRATE (baud),
        .rx_bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int valid_rise = 0;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Event counters sampled mid-cycle.
    always @(negedge i_clk) begin
        if (bus.o_frame_err === 1'b1) ferr_cnt++;
        if (bus.o_rx_valid === 1'b1 && !valid_prev) valid_rise++;
        valid_prev = bus.o_rx_valid;
    end

    // Hard stop if the bench itself stalls.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive nbits pin-bits of an 8N1 frame; glitch_mask inverts one cycle at
    // the centre of each selected data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb,
                              input int nbits, input logic [7:0] glitch_mask);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge i_clk);
                i_uart_rx = f[b];
                if (b >= 1 && b <= 8 && c == cpb / 2 && glitch_mask[b-1])
                    i_uart_rx = ~f[b];
            end
        end
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.o_rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic ack_pulse();
        @(negedge i_clk);
        bus.i_rx_ack = 1'b1;
        @(negedge i_clk);
        bus.i_rx_ack = 1'b0;
    endtask

    initial begin
        logic       ok;
        logic [7:0] exp_b;
        int         ferr_base;
        int         rise_base;

        i_rst      = 1'b1;
        i_uart_rx  = 1'b1;
        baud       = 12'd868;
        bus.i_rx_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_byte",  {24'd0, bus.o_rx_byte}, 32'h00);
        check("rst_valid", {31'd0, bus.o_rx_valid}, 32'd0);
        check("rst_ferr",  {31'd0, bus.o_frame_err}, 32'd0);
        check("rst_ovr",   {31'd0, bus.o_overrun}, 32'd0);
        check("rst_busy",  {31'd0, bus.o_rx_busy}, 32'd0);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // Single byte at 868 clocks/bit, held until acknowledged.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 868, 10, 8'h00);
        wait_valid(1000, ok);
        check("a5_timeout", {31'd0, ok}, 32'd1);
        exp_b = exp_q.pop_front();
        check("a5_byte", {24'd0, bus.o_rx_byte}, {24'd0, exp_b});
        check("a5_one_delivery", valid_rise, 1);
        check("a5_no_ferr", ferr_cnt, 0);
        repeat (50) @(negedge i_clk);
        check("a5_held_valid", {31'd0, bus.o_rx_valid}, 32'd1);
        check("a5_held_byte", {24'd0, bus.o_rx_byte}, 32'hA5);
        ack_pulse();
        check("a5_ack_clears", {31'd0, bus.o_rx_valid}, 32'd0);

        // 100-cycle low glitch on the idle line is a false start.
        @(negedge i_clk);
        i_uart_rx = 1'b0;
        repeat (99) @(negedge i_clk);
        check("glitch_busy", {31'd0, bus.o_rx_busy}, 32'd1);
        @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (340) @(negedge i_clk);
        check("glitch_idle", {31'd0, bus.o_rx_busy}, 32'd0);
        check("glitch_no_valid", valid_rise, 1);
        check("glitch_no_ferr", ferr_cnt, 0);

        // Framing error followed by a long break.
        baud = 12'd64;
        repeat (2) @(negedge i_clk);
        ferr_base = ferr_cnt;
        send_frame(8'h3C, 1'b0, 64, 10, 8'h00);
        repeat (20 * 64) @(negedge i_clk);
        check("break_one_ferr", ferr_cnt - ferr_base, 1);
        check("break_no_valid", {31'd0, bus.o_rx_valid}, 32'd0);
        check("break_busy", {31'd0, bus.o_rx_busy}, 32'd1);
        i_uart_rx = 1'b1;
        repeat (6) @(negedge i_clk);
        check("break_released", {31'd0, bus.o_rx_busy}, 32'd0);
        check("break_ferr_total", ferr_cnt - ferr_base, 1);

        // Two back-to-back frames without ack: second overwrites the first.
        rise_base = valid_rise;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, 64, 10, 8'h00);
        send_frame(8'h22, 1'b1, 64, 10, 8'h00);
        wait_valid(200, ok);
        check("ovr_timeout", {31'd0, ok}, 32'd1);
        exp_b = exp_q.pop_front();
        exp_b = exp_q.pop_front();
        check("ovr_byte", {24'd0, bus.o_rx_byte}, {24'd0, exp_b});
        check("ovr_flag", {31'd0, bus.o_overrun}, 32'd1);
        check("ovr_single_rise", valid_rise - rise_base, 1);
        ack_pulse();
        check("ovr_ack_valid", {31'd0, bus.o_rx_valid}, 32'd0);
        check("ovr_ack_flag", {31'd0, bus.o_overrun}, 32'd0);

        // Reset in the middle of data bit 3, then a clean frame.
        send_frame(8'hFF, 1'b1, 64, 4, 8'h00);
        @(negedge i_clk);
        i_uart_rx = 1'b1;
        repeat (31) @(negedge i_clk);
        check("midrst_busy_before", {31'd0, bus.o_rx_busy}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_byte",  {24'd0, bus.o_rx_byte}, 32'h00);
        check("midrst_valid", {31'd0, bus.o_rx_valid}, 32'd0);
        check("midrst_ferr",  {31'd0, bus.o_frame_err}, 32'd0);
        check("midrst_ovr",   {31'd0, bus.o_overrun}, 32'd0);
        check("midrst_busy",  {31'd0, bus.o_rx_busy}, 32'd0);
        i_rst = 1'b0;
        repeat (70) @(negedge i_clk);
        check("midrst_no_partial", {31'd0, bus.o_rx_valid}, 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 64, 10, 8'h00);
        wait_valid(200, ok);
        check("5a_timeout", {31'd0, ok}, 32'd1);
        exp_b = exp_q.pop_front();
        check("5a_byte", {24'd0, bus.o_rx_byte}, {24'd0, exp_b});
        ack_pulse();

        // One-cycle inverted glitch at each data-bit sample point.
        baud = 12'd16;
        repeat (2) @(negedge i_clk);
        ferr_base = ferr_cnt;
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h96);
`else
        exp_q.push_back(8'h69);
`endif
        send_frame(8'h96, 1'b1, 16, 10, 8'hFF);
        wait_valid(100, ok);
        check("maj_timeout", {31'd0, ok}, 32'd1);
        exp_b = exp_q.pop_front();
        check("maj_byte", {24'd0, bus.o_rx_byte}, {24'd0, exp_b});
        check("maj_no_ferr", ferr_cnt - ferr_base, 0);
        ack_pulse();
        check("maj_ack", {31'd0, bus.o_rx_valid}, 32'd0);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
